// File: rtl/dds_pkg.sv
// ============================================================================
// Module   : dds_pkg
// Brief    : Shared constants and duty-word reduction helper for the DDS chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

  localparam int DDS_M     = 12;
  localparam int DDS_OUT_W = 8;

  // Round-half-up of the top out_w bits of a prod_w-bit product, saturating
  // at all-ones. Operates on a zero-extended 64-bit container so any stage
  // with prod_w <= 63 can share it; callers truncate the result to out_w.
  function automatic logic [63:0] round_sat(input logic [63:0] product,
                                            input int          prod_w,
                                            input int          out_w);
    logic [63:0] t;
    logic [63:0] q;
    logic [63:0] ones;
    logic        r;
    t    = product >> (prod_w - out_w - 1);
    r    = t[0];
    q    = t >> 1;
    ones = (64'd1 << out_w) - 64'd1;
    if (r && (q == ones)) return ones;
    return q + {63'd0, r};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dds_pwm_out_pwm_core.sv
// ============================================================================
// Module   : pwm_core
// Brief    : Free-running PWM counter, frame tick, duty register and
//            registered comparator driving the DAC pin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_core #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OUT_W-1:0] duty_i,
  output logic [OUT_W-1:0] duty_o,
  output logic             last_o,
  output logic             frame_tick_o,
  output logic             pwm_o
);

  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] duty_q, duty_d;
  logic             tick_q, tick_d;
  logic             pwm_q, pwm_d;
  logic             last;

  assign last = (cnt_q == {OUT_W{1'b1}});

  always_comb begin
    cnt_d  = cnt_q + OUT_W'(1);
    duty_d = load_i ? duty_i : duty_q;
    tick_d = last;
    // Compare against the duty in force; a freshly loaded value first
    // takes effect on the count-0 compare of the next frame.
    pwm_d  = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      tick_q <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty_o       = duty_q;
  assign last_o       = last;
  assign frame_tick_o = tick_q;
  assign pwm_o        = pwm_q;

endmodule

`default_nettype wire

// File: rtl/dds_pwm_out.sv
// ============================================================================
// Module   : dds_pwm_out
// Brief    : DDS output stage: captures multiplier products, reduces them to
//            a duty word and hands them to the PWM core at frame boundaries.
//            Define DDS_PWM_ERRFB_EN for first-order error-feedback reduction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_pwm_out
  import dds_pkg::*;
#(
  parameter int M     = DDS_M,
  parameter int OUT_W = DDS_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*M-1:0]   prod_in,
  input  logic             prod_valid,
  input  logic             ovr_clr,
  output logic             pwm_out,
  output logic [OUT_W-1:0] duty_out,
  output logic             frame_tick,
  output logic             overrun
);

  localparam int PW = 2 * M;
  localparam int FW = PW - OUT_W;

  logic [OUT_W-1:0] result;
  logic [OUT_W-1:0] pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic             overrun_q, overrun_d;
  logic             cnt_last;
  logic             load;

`ifdef DDS_PWM_ERRFB_EN
  logic [FW-1:0]    res_acc_q, res_acc_d;
  logic             carry;
  logic [OUT_W-1:0] q_top;

  assign q_top              = prod_in[PW-1 -: OUT_W];
  assign {carry, res_acc_d} = {1'b0, res_acc_q} + {1'b0, prod_in[FW-1:0]};
  assign result             = (carry && (q_top == {OUT_W{1'b1}})) ? {OUT_W{1'b1}}
                                                                   : q_top + OUT_W'(carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             res_acc_q <= '0;
    else if (prod_valid) res_acc_q <= res_acc_d;
  end
`else
  assign result = OUT_W'(round_sat(64'(prod_in), PW, OUT_W));
`endif

  assign load = cnt_last & pend_flag_q;

  always_comb begin
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    overrun_d   = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (prod_valid) begin
      pending_d   = result;
      pend_flag_d = 1'b1;
      // A capture coinciding with a load is not a drop: the old value moves on.
      if (pend_flag_q && !load) overrun_d = 1'b1;
    end else if (load) begin
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      overrun_q   <= overrun_d;
    end
  end

  pwm_core #(
    .OUT_W (OUT_W)
  ) u_pwm_core (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .duty_i       (pending_q),
    .duty_o       (duty_out),
    .last_o       (cnt_last),
    .frame_tick_o (frame_tick),
    .pwm_o        (pwm_out)
  );

  assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_pwm_out.sv
// ============================================================================
// Module   : tb_dds_pwm_out
// Brief    : Directed self-checking bench for dds_pwm_out (M=12, OUT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_pwm_out;

  localparam int M     = 12;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2*M-1:0]   prod_in;
  logic             prod_valid;
  logic             ovr_clr;
  logic             pwm_out;
  logic [OUT_W-1:0] duty_out;
  logic             frame_tick;
  logic             overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hi, hi2;

  dds_pwm_out #(.M(M), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .ovr_clr    (ovr_clr),
    .pwm_out    (pwm_out),
    .duty_out   (duty_out),
    .frame_tick (frame_tick),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Advance to the negedge of the next cycle with frame_tick high (bounded).
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 600);
    chk("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // One-cycle capture strobe starting at the current negedge.
  task automatic strobe(input logic [2*M-1:0] v);
    prod_in    = v;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  // Count pin-high cycles over one frame (256 samples).
  task automatic count_high(output int h);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) h++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    ovr_clr    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm",      {31'd0, pwm_out},    32'd0);
    chk("rst_duty",     {24'd0, duty_out},   32'd0);
    chk("rst_tick",     {31'd0, frame_tick}, 32'd0);
    chk("rst_overrun",  {31'd0, overrun},    32'd0);
    rst = 1'b0;

`ifdef DDS_PWM_ERRFB_EN
    wait_tick();
    for (int i = 0; i < 8; i++) begin
      strobe(24'h018000);
      wait_tick();
      chk("errfb_duty", {24'd0, duty_out}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
`else
    count_high(hi);
    chk("idle_pin_high", hi, 0);

    // Half scale
    wait_tick();
    strobe(24'h800000);
    wait_tick();
    chk("half_duty", {24'd0, duty_out}, 32'h80);
    count_high(hi);
    chk("half_high_cnt", hi, 128);
    chk("half_overrun", {31'd0, overrun}, 32'd0);

    // Rounding (count_high leaves us on a tick cycle)
    strobe(24'h127FFF);
    wait_tick();
    chk("round_down", {24'd0, duty_out}, 32'h12);
    strobe(24'h128000);
    wait_tick();
    chk("round_up", {24'd0, duty_out}, 32'h13);
    strobe(24'hFF8000);
    wait_tick();
    chk("round_sat", {24'd0, duty_out}, 32'hFF);
    count_high(hi);
    chk("sat_high_cnt", hi, 255);

    // Overrun
    strobe(24'h400000);
    strobe(24'h600000);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_tick();
    chk("ovr_newest_duty", {24'd0, duty_out}, 32'h60);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    strobe(24'h100000);
    prod_in    = 24'h300000;
    prod_valid = 1'b1;
    ovr_clr    = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    ovr_clr    = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    wait_tick();
    chk("ovr2_duty", {24'd0, duty_out}, 32'h30);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr2_cleared", {31'd0, overrun}, 32'd0);

    // Boundary race: capture exactly in the cnt=0xFF cycle
    wait_tick();
    strobe(24'h400000);
    repeat (254) @(negedge clk);
    prod_in    = 24'h200000;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("race_tick", {31'd0, frame_tick}, 32'd1);
    chk("race_duty_first", {24'd0, duty_out}, 32'h40);
    chk("race_no_overrun", {31'd0, overrun}, 32'd0);
    count_high(hi);
    chk("race_high_cnt", hi, 64);
    chk("race_duty_second", {24'd0, duty_out}, 32'h20);
    chk("race_no_overrun2", {31'd0, overrun}, 32'd0);

    // Reset mid-frame
    strobe(24'hC00000);
    wait_tick();
    chk("pre_rst_duty", {24'd0, duty_out}, 32'hC0);
    strobe(24'h100000);
    strobe(24'h100000);
    chk("pre_rst_overrun", {31'd0, overrun}, 32'd1);
    repeat (8'h35) @(negedge clk);
    chk("pre_rst_pin", {31'd0, pwm_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_pwm",     {31'd0, pwm_out},  32'd0);
    chk("midrst_duty",    {24'd0, duty_out}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_high(hi);
    count_high(hi2);
    chk("post_rst_pin_high", hi + hi2, 0);
    chk("post_rst_duty", {24'd0, duty_out}, 32'd0);

    // Recovery with minimum non-zero duty
    wait_tick();
    strobe(24'h017FFF);
    wait_tick();
    chk("min_duty", {24'd0, duty_out}, 32'h01);
    count_high(hi);
    chk("min_high_cnt", hi, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
